// File: rtl/amt_repair_sequencer_pkg.sv
// Shared types and constants for the AMT->RMT repair sequencer.
// Holds the repair state enum, the packet count and the lane-mask helper.
package amt_repair_sequencer_pkg;
  localparam int DEPTH              = 34;
  localparam int INDEX              = 6;
  localparam int WIDTH              = 7;
  localparam int N_PACKETS          = 8;
  localparam int NUM_REPAIR_PACKETS = (DEPTH + N_PACKETS - 1) / N_PACKETS;

  // One spare bit so ptr + N_PACKETS never wraps past the last packet
  typedef logic [INDEX:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } repair_state_e;

  function automatic logic [N_PACKETS-1:0] lane_mask(input ptr_t ptr);
    lane_mask = '0;
    for (int i = 0; i < N_PACKETS; i++) begin
      lane_mask[i] = (int'(ptr) + i) < DEPTH;
    end
  endfunction
endpackage

// File: rtl/amt_repair_sequencer_if.sv
// Repair bus between the sequencer, the AMT repair read ports and the RMT repair write ports.
// master = sequencer side, slave = AMT/RMT/rename side.
interface amt_repair_sequencer_if;
  import amt_repair_sequencer_pkg::*;

  logic                              recoverFlag_i;
  logic                              amtReady_i;
  logic                              rmtReady_i;
  logic                              repairFlag_o;
  logic [N_PACKETS-1:0][INDEX-1:0]   repairAddr_o;
  logic [N_PACKETS-1:0][WIDTH-1:0]   repairData_i;
  logic [N_PACKETS-1:0][INDEX-1:0]   rmtRepairAddr_o;
  logic [N_PACKETS-1:0][WIDTH-1:0]   rmtRepairData_o;
  logic [N_PACKETS-1:0]              rmtRepairWe_o;
  logic                              repairBusy_o;
  logic                              repairDone_o;

  modport master (
    input  recoverFlag_i, amtReady_i, rmtReady_i, repairData_i,
    output repairFlag_o, repairAddr_o, rmtRepairAddr_o, rmtRepairData_o,
           rmtRepairWe_o, repairBusy_o, repairDone_o
  );

  modport slave (
    output recoverFlag_i, amtReady_i, rmtReady_i, repairData_i,
    input  repairFlag_o, repairAddr_o, rmtRepairAddr_o, rmtRepairData_o,
           rmtRepairWe_o, repairBusy_o, repairDone_o
  );
endinterface

// File: rtl/amt_repair_sequencer_repair_packet_reg.sv
// Registered RMT write stage: captures one packet of addr/data/lane-mask per accepted read.
// Write enables drop to zero on any cycle without a capture, or when a restart flushes it.
module repair_packet_reg
  import amt_repair_sequencer_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            capture_i,
  input  logic                            flush_i,
  input  logic [N_PACKETS-1:0][INDEX-1:0] addr_i,
  input  logic [N_PACKETS-1:0][WIDTH-1:0] data_i,
  input  logic [N_PACKETS-1:0]            mask_i,
  output logic [N_PACKETS-1:0][INDEX-1:0] addr_o,
  output logic [N_PACKETS-1:0][WIDTH-1:0] data_o,
  output logic [N_PACKETS-1:0]            we_o
);
  logic [N_PACKETS-1:0][INDEX-1:0] addr_q, addr_d;
  logic [N_PACKETS-1:0][WIDTH-1:0] data_q, data_d;
  logic [N_PACKETS-1:0]            we_q, we_d;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    we_d   = '0;
    if (capture_i && !flush_i) begin
      addr_d = addr_i;
      data_d = data_i;
      we_d   = mask_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign addr_o = addr_q;
  assign data_o = data_q;
  assign we_o   = we_q;
endmodule

// File: rtl/amt_repair_sequencer.sv
// Walks the AMT N_PACKETS entries per cycle on recovery and replays them into the RMT.
// Optional macro AMT_REPAIR_PERF_EN adds repairCount_o / repairStallCycles_o counters.
//
// state | meaning
// IDLE  | no recovery in progress
// WAIT  | recovery requested, waiting for AMT and RMT ready
// READ  | reading one packet per cycle from the AMT, ptr advances on accept
// DRAIN | last packet presented to the RMT, done pulse
module amt_repair_sequencer
  import amt_repair_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  amt_repair_sequencer_if.master    bus
`ifdef AMT_REPAIR_PERF_EN
  ,
  output logic [31:0]               repairCount_o,
  output logic [31:0]               repairStallCycles_o
`endif
);
  repair_state_e                   state_q, state_d;
  ptr_t                            ptr_q, ptr_d;
  logic                            go;
  logic                            capture;
  logic [N_PACKETS-1:0]            mask;
  logic [N_PACKETS-1:0][INDEX-1:0] lane_addr;

  // A missing AMT ready stalls the walk exactly like RMT backpressure
  assign go   = bus.amtReady_i && bus.rmtReady_i;
  assign mask = lane_mask(ptr_q);

  always_comb begin
    lane_addr = '0;
    for (int i = 0; i < N_PACKETS; i++) begin
      lane_addr[i] = mask[i] ? INDEX'(ptr_q + ptr_t'(i)) : INDEX'(DEPTH - 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    capture          = 1'b0;
    bus.repairFlag_o = 1'b0;
    bus.repairAddr_o = '0;
    bus.repairBusy_o = (state_q != IDLE);
    bus.repairDone_o = 1'b0;
    case (state_q)
      IDLE: ;
      WAIT: begin
        if (go) begin
          state_d = READ;
          ptr_d   = '0;
        end
      end
      READ: begin
        bus.repairFlag_o = 1'b1;
        bus.repairAddr_o = lane_addr;
        if (go) begin
          capture = 1'b1;
          ptr_d   = ptr_q + ptr_t'(N_PACKETS);
          if (int'(ptr_q) + N_PACKETS >= DEPTH) state_d = DRAIN;
        end
      end
      DRAIN: begin
        bus.repairDone_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Restart wins over everything, including the DRAIN->IDLE step
    if (bus.recoverFlag_i) begin
      state_d = WAIT;
      ptr_d   = '0;
    end
  end

  repair_packet_reg u_packet_reg (
    .clk       (clk),
    .reset     (reset),
    .capture_i (capture),
    .flush_i   (bus.recoverFlag_i),
    .addr_i    (lane_addr),
    .data_i    (bus.repairData_i),
    .mask_i    (mask),
    .addr_o    (bus.rmtRepairAddr_o),
    .data_o    (bus.rmtRepairData_o),
    .we_o      (bus.rmtRepairWe_o)
  );

`ifdef AMT_REPAIR_PERF_EN
  logic [31:0] count_q, stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == DRAIN && count_q != '1) count_q <= count_q + 32'd1;
      if (state_q == READ && !go && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign repairCount_o       = count_q;
  assign repairStallCycles_o = stall_q;
`endif
endmodule

// File: tb/tb_amt_repair_sequencer.sv
// Bench for amt_repair_sequencer: packet-level reference model checked every cycle,
// directed recovery scenarios with literal expectations, then randomized traffic.
module tb_amt_repair_sequencer;
  import amt_repair_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  amt_repair_sequencer_if bus();
`ifdef AMT_REPAIR_PERF_EN
  logic [31:0] perf_cnt, perf_stall;
`endif

  amt_repair_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef AMT_REPAIR_PERF_EN
    ,
    .repairCount_o       (perf_cnt),
    .repairStallCycles_o (perf_stall)
`endif
  );

  // AMT mock: zero-latency read of the committed map
  logic [WIDTH-1:0] amt [DEPTH];
  always_comb begin
    bus.repairData_i = '0;
    for (int i = 0; i < N_PACKETS; i++)
      if (int'(bus.repairAddr_o[i]) < DEPTH) bus.repairData_i[i] = amt[bus.repairAddr_o[i]];
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // Reference model: phase 0 idle, 1 waiting for ready, 2 walking packets, 3 done cycle
  int                              m_phase = 0;
  int                              m_pkt   = 0;
  logic [N_PACKETS-1:0]            m_we    = '0;
  logic [N_PACKETS-1:0][INDEX-1:0] m_waddr = '0;
  logic [N_PACKETS-1:0][WIDTH-1:0] m_wdata = '0;
  logic [31:0]                     m_cnt   = '0;
  logic [31:0]                     m_stall = '0;

  always @(negedge clk) begin : model
    logic [N_PACKETS-1:0][INDEX-1:0] e_raddr, amask;
    logic [N_PACKETS-1:0][WIDTH-1:0] dmask;
    logic                            rdy;
    int                              a;
    if (!reset) begin
      m_phase = 0; m_pkt = 0; m_we = '0; m_cnt = '0; m_stall = '0;
    end
    e_raddr = '0;
    amask   = '0;
    dmask   = '0;
    for (int i = 0; i < N_PACKETS; i++) begin
      a = m_pkt * N_PACKETS + i;
      if (m_phase == 2) e_raddr[i] = INDEX'((a < DEPTH) ? a : DEPTH - 1);
      if (m_we[i]) begin
        amask[i] = '1;
        dmask[i] = '1;
      end
    end
    chk("busy", 64'(bus.repairBusy_o), 64'(m_phase != 0));
    chk("repair_flag", 64'(bus.repairFlag_o), 64'(m_phase == 2));
    chk("repair_done", 64'(bus.repairDone_o), 64'(m_phase == 3));
    chk("repair_addr", 64'(bus.repairAddr_o), 64'(e_raddr));
    chk("rmt_we", 64'(bus.rmtRepairWe_o), 64'(m_we));
    chk("rmt_addr", 64'(bus.rmtRepairAddr_o & amask), 64'(m_waddr & amask));
    chk("rmt_data", 64'(bus.rmtRepairData_o & dmask), 64'(m_wdata & dmask));
    if (!reset) begin
      chk("reset_rmt_addr", 64'(bus.rmtRepairAddr_o), 64'(0));
      chk("reset_rmt_data", 64'(bus.rmtRepairData_o), 64'(0));
    end
`ifdef AMT_REPAIR_PERF_EN
    chk("perf_count", 64'(perf_cnt), 64'(m_cnt));
    chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
    // Advance using the inputs the DUT will sample at the coming edge
    rdy = bus.amtReady_i && bus.rmtReady_i;
    if (reset) begin
      if (m_phase == 3 && m_cnt != '1) m_cnt++;
      if (m_phase == 2 && !rdy && m_stall != '1) m_stall++;
      m_we = '0;
      if (m_phase == 2 && rdy && !bus.recoverFlag_i) begin
        for (int i = 0; i < N_PACKETS; i++) begin
          a = m_pkt * N_PACKETS + i;
          if (a < DEPTH) begin
            m_we[i]    = 1'b1;
            m_waddr[i] = INDEX'(a);
            m_wdata[i] = amt[a];
          end
        end
      end
      if (bus.recoverFlag_i) begin
        m_phase = 1;
        m_pkt   = 0;
      end else if (m_phase == 1 && rdy) begin
        m_phase = 2;
        m_pkt   = 0;
      end else if (m_phase == 2 && rdy) begin
        m_pkt++;
        if (m_pkt == NUM_REPAIR_PACKETS) m_phase = 3;
      end else if (m_phase == 3) begin
        m_phase = 0;
      end
    end
  end

  // One recovery scenario; cycle 0 carries the recoverFlag_i pulse
  task automatic run(input int n, input int a0, input int a1, input int r0, input int r1,
                     input int rp, input int rst_at,
                     output int first_flag, output int done_cyc, output int n_done,
                     output int n_busy, output int we_pop, output logic [N_PACKETS-1:0] last_we,
                     output int la0, output int la1, output int ld0, output int ld1);
    first_flag = -1; done_cyc = -1; n_done = 0; n_busy = 0; we_pop = 0;
    last_we = '0; la0 = 0; la1 = 0; ld0 = 0; ld1 = 0;
    for (int c = 0; c < n; c++) begin
      bus.recoverFlag_i = (c == 0) || (c == rp);
      bus.amtReady_i    = !(c >= a0 && c < a1);
      bus.rmtReady_i    = !(c >= r0 && c < r1);
      reset             = !(c == rst_at || c == rst_at + 1);
      @(negedge clk);
      if (bus.repairFlag_o && first_flag < 0) first_flag = c;
      if (bus.repairBusy_o) n_busy++;
      we_pop += $countones(bus.rmtRepairWe_o);
      if (bus.repairDone_o) begin
        n_done++;
        done_cyc = c;
        last_we  = bus.rmtRepairWe_o;
        la0 = int'(bus.rmtRepairAddr_o[0]);
        la1 = int'(bus.rmtRepairAddr_o[1]);
        ld0 = int'(bus.rmtRepairData_o[0]);
        ld1 = int'(bus.rmtRepairData_o[1]);
      end
      @(posedge clk);
      #1;
    end
    bus.recoverFlag_i = 1'b0;
    bus.amtReady_i    = 1'b1;
    bus.rmtReady_i    = 1'b1;
    reset             = 1'b1;
  endtask

  initial begin
    int ff, dc, nd, nb, wp, la0, la1, ld0, ld1;
    logic [N_PACKETS-1:0] lw;
    bus.recoverFlag_i = 1'b0;
    bus.amtReady_i    = 1'b1;
    bus.rmtReady_i    = 1'b1;
    for (int k = 0; k < DEPTH; k++) amt[k] = WIDTH'(k + 40);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Unstalled walk
    run(20, 0, 0, 0, 0, -1, -10, ff, dc, nd, nb, wp, lw, la0, la1, ld0, ld1);
    chk_i("t1_first_flag", ff, 2);
    chk_i("t1_done_cycle", dc, 7);
    chk_i("t1_done_count", nd, 1);
    chk_i("t1_busy_cycles", nb, 7);
    chk_i("t1_writes", wp, 34);
    chk("t1_last_mask", 64'(lw), 64'(8'h03));
    chk_i("t1_last_addr0", la0, 32);
    chk_i("t1_last_addr1", la1, 33);
    chk_i("t1_last_data0", ld0, 72);
    chk_i("t1_last_data1", ld1, 73);

    // RMT stalls for 3 cycles on the second packet
    run(20, 0, 0, 3, 6, -1, -10, ff, dc, nd, nb, wp, lw, la0, la1, ld0, ld1);
    chk_i("t2_done_cycle", dc, 10);
    chk_i("t2_done_count", nd, 1);
    chk_i("t2_writes", wp, 34);
    chk("t2_last_mask", 64'(lw), 64'(8'h03));
`ifdef AMT_REPAIR_PERF_EN
    chk("perf_two_repairs", 64'(perf_cnt), 64'(2));
    chk("perf_three_stalls", 64'(perf_stall), 64'(3));
`endif

    // AMT not ready for 5 cycles while waiting
    run(24, 1, 6, 0, 0, -1, -10, ff, dc, nd, nb, wp, lw, la0, la1, ld0, ld1);
    chk_i("t3_first_flag", ff, 7);
    chk_i("t3_done_cycle", dc, 12);

    // Restart while reading ptr=16
    run(24, 0, 0, 0, 0, 4, -10, ff, dc, nd, nb, wp, lw, la0, la1, ld0, ld1);
    chk_i("t4_done_cycle", dc, 11);
    chk_i("t4_done_count", nd, 1);
    chk_i("t4_writes", wp, 50);

    // Reset while reading ptr=24
    run(20, 0, 0, 0, 0, -1, 5, ff, dc, nd, nb, wp, lw, la0, la1, ld0, ld1);
    chk_i("t5_done_count", nd, 0);
    chk_i("t5_writes", wp, 16);
    chk_i("t5_busy_cycles", nb, 4);

    // Randomized traffic against the model
    for (int k = 0; k < DEPTH; k++) amt[k] = WIDTH'($urandom);
    for (int c = 0; c < 3000; c++) begin
      bus.recoverFlag_i = ($urandom_range(0, 39) == 0);
      bus.amtReady_i    = ($urandom_range(0, 7) != 0);
      bus.rmtReady_i    = ($urandom_range(0, 5) != 0);
      reset             = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      #1;
    end
    bus.recoverFlag_i = 1'b0;
    bus.amtReady_i    = 1'b1;
    bus.rmtReady_i    = 1'b1;
    reset             = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
